// File: rtl/shift_ctrl_32_if.sv
// Command-side bundle for shift_ctrl_32: request fields plus status/result.
// The keep field exists only when SHIFT_CTRL_CHAIN_EN is defined.
interface shift_ctrl_32_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
);
    logic             start;
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] din;
`ifdef SHIFT_CTRL_CHAIN_EN
    logic             keep;
`endif
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (
        output start,
        output op,
        output amt,
        output din,
`ifdef SHIFT_CTRL_CHAIN_EN
        output keep,
`endif
        input  busy,
        input  done,
        input  err,
        input  result
    );

    modport slave (
        input  start,
        input  op,
        input  amt,
        input  din,
`ifdef SHIFT_CTRL_CHAIN_EN
        input  keep,
`endif
        output busy,
        output done,
        output err,
        output result
    );
endinterface

// File: rtl/shift_ctrl_32.sv
// Command sequencer for a 32-bit DM74LS194-chain shifter: load, N single-bit steps, capture.
// Optional macro SHIFT_CTRL_CHAIN_EN adds keep (shift current sh_q contents, skipping LOAD).
module shift_ctrl_32 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
) (
    input  logic             clk,
    input  logic             clear,
    shift_ctrl_32_if.slave   bus,
    input  logic [WIDTH-1:0] sh_q,
    output logic [1:0]       S,
    output logic             SR,
    output logic             SL,
    output logic [WIDTH-1:0] PData
);

    localparam logic [2:0] OpLoad = 3'b000;
    localparam logic [2:0] OpShl  = 3'b001;
    localparam logic [2:0] OpShr  = 3'b010;
    localparam logic [2:0] OpSar  = 3'b011;
    localparam logic [2:0] OpRol  = 3'b100;
    localparam logic [2:0] OpRor  = 3'b101;

    localparam logic [1:0] ModeHold  = 2'b00;
    localparam logic [1:0] ModeRight = 2'b01;
    localparam logic [1:0] ModeLeft  = 2'b10;
    localparam logic [1:0] ModeLoad  = 2'b11;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StCapt} state_e;

    state_e           state_q;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] cnt_q;
    logic [1:0]       s_q;
    logic [WIDTH-1:0] pdata_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] result_q;
    logic             keep_cmd;

    function automatic logic is_shift(input logic [2:0] o);
        return (o == OpShl) || (o == OpShr) || (o == OpSar) || (o == OpRol) || (o == OpRor);
    endfunction

    function automatic logic is_reserved(input logic [2:0] o);
        return o[2] & o[1];
    endfunction

    function automatic logic [1:0] shift_mode(input logic [2:0] o);
        return ((o == OpShr) || (o == OpSar) || (o == OpRor)) ? ModeRight : ModeLeft;
    endfunction

    always_comb begin
`ifdef SHIFT_CTRL_CHAIN_EN
        keep_cmd = bus.keep;
`else
        keep_cmd = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q  <= StIdle;
            op_q     <= OpLoad;
            cnt_q    <= '0;
            s_q      <= ModeHold;
            pdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        cnt_q   <= bus.amt;
                        pdata_q <= bus.din;
                        if (!keep_cmd) begin
                            state_q <= StLoad;
                            s_q     <= ModeLoad;
                        end else if (is_shift(bus.op) && (bus.amt != '0)) begin
                            state_q <= StShift;
                            s_q     <= shift_mode(bus.op);
                        end else begin
                            state_q <= StCapt;
                            s_q     <= ModeHold;
                        end
                    end
                end
                StLoad: begin
                    if (is_shift(op_q) && (cnt_q != '0)) begin
                        state_q <= StShift;
                        s_q     <= shift_mode(op_q);
                    end else begin
                        state_q <= StCapt;
                        s_q     <= ModeHold;
                    end
                end
                StShift: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == AMT_W'(1)) begin
                        state_q <= StCapt;
                        s_q     <= ModeHold;
                    end
                end
                StCapt: begin
                    result_q <= sh_q;
                    done_q   <= 1'b1;
                    err_q    <= is_reserved(op_q);
                    pdata_q  <= '0;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    s_q     <= ModeHold;
                end
            endcase
        end
    end

    // Serial feed depends on live sh_q so rotates wrap the bit leaving the chain this cycle.
    always_comb begin
        SR = 1'b0;
        SL = 1'b0;
        if (s_q == ModeRight) begin
            if (op_q == OpSar) begin
                SR = sh_q[WIDTH-1];
            end else if (op_q == OpRor) begin
                SR = sh_q[0];
            end
        end else if ((s_q == ModeLeft) && (op_q == OpRol)) begin
            SL = sh_q[WIDTH-1];
        end
    end

    assign S          = s_q;
    assign PData      = pdata_q;
    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;

endmodule
